// File: rtl/ula_arbiter.sv
// Two-port arbiter in front of a shared 20-bit ALU (add/or/and/not + equality flag).
// Round-robin, or fixed priority to port 0 with a starvation guard for port 1.
`timescale 1ns/1ps
module ula_arbiter #(
    parameter int WIDTH      = 20,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int MAX_WAIT   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       ctrl0,
    input  logic [1:0]       ctrl1,
    input  logic [WIDTH-1:0] opA0,
    input  logic [WIDTH-1:0] opB0,
    input  logic [WIDTH-1:0] opA1,
    input  logic [WIDTH-1:0] opB1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             ulaZero,
    output logic             resultValid,
    output logic             resultId,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               res_id_q, res_id_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               win;
    logic [WIDTH-1:0]   alu;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = BUSY;
            BUSY:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        ack0        = (state_q == DONE) && !id_q;
        ack1        = (state_q == DONE) && id_q;
        resultValid = (state_q == DONE);
        busy        = (state_q != IDLE);
        result      = result_q;
        ulaZero     = zero_q;
        resultId    = res_id_q;
    end

    // a lone requester always wins; ties depend on the arbitration mode
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            if (FIXED_PRIO) win = (wait_cnt_q >= 4'(MAX_WAIT));
            else            win = ~last_grant_q;
        end
    end

    always_comb begin
        alu = '0;
        unique case (ctrl_q)
            2'b00: alu = opa_q + opb_q;
            2'b01: alu = opa_q | opb_q;
            2'b10: alu = opa_q & opb_q;
            2'b11: alu = ~opa_q;
            default: alu = '0;
        endcase
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        id_d         = id_q;
        result_d     = result_q;
        zero_d       = zero_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        if (state_q == IDLE && (req0 || req1)) begin
            ctrl_d       = win ? ctrl1 : ctrl0;
            opa_d        = win ? opA1  : opA0;
            opb_d        = win ? opB1  : opB0;
            id_d         = win;
            last_grant_d = win;
            if (win)
                wait_cnt_d = '0;
            else if (req1 && wait_cnt_q != 4'hF)
                wait_cnt_d = wait_cnt_q + 4'd1;
        end
        if (state_q == BUSY) begin
            result_d = alu;
            zero_d   = (opa_q == opb_q);
            res_id_d = id_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            id_q         <= id_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: a round-robin instance and a fixed-priority
// instance (MAX_WAIT = 2) share clock and reset.
`timescale 1ns/1ps
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req0, req1;
    logic [1:0]  ctrl0, ctrl1;
    logic [19:0] opA0, opB0, opA1, opB1;
    logic        ack0, ack1, zero, rvalid, rid, busy;
    logic [19:0] result;

    logic        f_req0, f_req1;
    logic [1:0]  f_ctrl0, f_ctrl1;
    logic [19:0] f_opA0, f_opB0, f_opA1, f_opB1;
    logic        f_ack0, f_ack1, f_zero, f_rvalid, f_rid, f_busy;
    logic [19:0] f_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.WIDTH(20), .FIXED_PRIO(1'b0), .MAX_WAIT(4)) u_rr (
        .clock(clk), .reset(rst),
        .req0(req0), .req1(req1), .ctrl0(ctrl0), .ctrl1(ctrl1),
        .opA0(opA0), .opB0(opB0), .opA1(opA1), .opB1(opB1),
        .ack0(ack0), .ack1(ack1), .result(result), .ulaZero(zero),
        .resultValid(rvalid), .resultId(rid), .busy(busy)
    );

    ula_arbiter #(.WIDTH(20), .FIXED_PRIO(1'b1), .MAX_WAIT(2)) u_fx (
        .clock(clk), .reset(rst),
        .req0(f_req0), .req1(f_req1), .ctrl0(f_ctrl0), .ctrl1(f_ctrl1),
        .opA0(f_opA0), .opB0(f_opB0), .opA1(f_opA1), .opB1(f_opB1),
        .ack0(f_ack0), .ack1(f_ack1), .result(f_result), .ulaZero(f_zero),
        .resultValid(f_rvalid), .resultId(f_rid), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated request on the round-robin instance, starting in IDLE at a negedge
    task automatic serve(input bit p, input logic [1:0] c,
                         input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] er, input bit ez, input string tag);
        if (!p) begin req0 = 1; ctrl0 = c; opA0 = a; opB0 = b; end
        else    begin req1 = 1; ctrl1 = c; opA1 = a; opB1 = b; end
        @(negedge clk);
        check({tag, "_busy1"}, busy, 1);
        check({tag, "_noack1"}, ack0 | ack1, 0);
        opA0 = ~opA0; opB0 = opB0 ^ 20'h5A5A5;
        opA1 = ~opA1; opB1 = opB1 ^ 20'hA5A5A;
        @(negedge clk);
        check({tag, "_ack0"}, ack0, !p);
        check({tag, "_ack1"}, ack1, p);
        check({tag, "_res"}, result, er);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_id"}, rid, p);
        check({tag, "_valid"}, rvalid, 1);
        req0 = 0; req1 = 0;
        @(negedge clk);
        check({tag, "_busy0"}, busy, 0);
        check({tag, "_valid0"}, rvalid, 0);
        check({tag, "_hold"}, result, er);
    endtask

    initial begin
        req0 = 0; req1 = 0; ctrl0 = 0; ctrl1 = 0;
        opA0 = 0; opB0 = 0; opA1 = 0; opB1 = 0;
        f_req0 = 0; f_req1 = 0; f_ctrl0 = 0; f_ctrl1 = 0;
        f_opA0 = 0; f_opB0 = 0; f_opA1 = 0; f_opB1 = 0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_valid", rvalid, 0);
        check("rst_id", rid, 0);
        check("rst_res", result, 0);
        check("rst_zero", zero, 0);
        check("rst_f_busy", f_busy, 0);
        rst = 0;

        // round-robin tie right after reset: port 0 wins first
        req0 = 1; ctrl0 = 2'b01; opA0 = 20'hFFC00; opB0 = 20'h00003;
        req1 = 1; ctrl1 = 2'b10; opA1 = 20'h00205; opB1 = 20'h0000F;
        @(negedge clk);
        check("tie_busy", busy, 1);
        @(negedge clk);
        check("tie_ack0", ack0, 1);
        check("tie_ack1a", ack1, 0);
        check("tie_res0", result, 20'hFFC03);
        check("tie_zero0", zero, 0);
        req0 = 0;
        @(negedge clk);
        check("tie_idle", busy, 0);
        check("tie_hold", result, 20'hFFC03);
        @(negedge clk);
        check("tie_busy2", busy, 1);
        @(negedge clk);
        check("tie_ack1", ack1, 1);
        check("tie_ack0b", ack0, 0);
        check("tie_res1", result, 20'h00005);
        check("tie_id1", rid, 1);
        req1 = 0;
        @(negedge clk);

        serve(0, 2'b00, 20'h00001, 20'h00001, 20'h00002, 1, "add11");
        serve(0, 2'b11, 20'hFFC00, 20'h12345, 20'h003FF, 0, "not");
        serve(1, 2'b00, 20'hFFFFF, 20'h00001, 20'h00000, 0, "ovf");
        serve(0, 2'b00, 20'h12345, 20'h12345, 20'h2468A, 1, "dbl");

        // continuous ties alternate; last grant was port 0
        req0 = 1; ctrl0 = 2'b00; opA0 = 20'h00001; opB0 = 20'h00002;
        req1 = 1; ctrl1 = 2'b01; opA1 = 20'h00010; opB1 = 20'h00001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            @(negedge clk);
            check($sformatf("rr%0d_ack1", i), ack1, (i % 2 == 0));
            check($sformatf("rr%0d_ack0", i), ack0, (i % 2 == 1));
            check($sformatf("rr%0d_res", i), result,
                  (i % 2 == 0) ? 20'h00011 : 20'h00003);
            if (i == 3) begin req0 = 0; req1 = 0; end
            @(negedge clk);
        end

        // fixed priority with MAX_WAIT = 2: port 1 gets every third grant
        f_req0 = 1; f_ctrl0 = 2'b10; f_opA0 = 20'hF0F0F; f_opB0 = 20'h0FFFF;
        f_req1 = 1; f_ctrl1 = 2'b00; f_opA1 = 20'h00010; f_opB1 = 20'h00020;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("fx%0d_busy", i), f_busy, 1);
            @(negedge clk);
            check($sformatf("fx%0d_ack1", i), f_ack1, (i % 3 == 2));
            check($sformatf("fx%0d_ack0", i), f_ack0, (i % 3 != 2));
            check($sformatf("fx%0d_id", i), f_rid, (i % 3 == 2));
            check($sformatf("fx%0d_res", i), f_result,
                  (i % 3 == 2) ? 20'h00030 : 20'h00F0F);
            check($sformatf("fx%0d_zero", i), {f_zero, f_rvalid}, 2'b01);
            if (i == 5) begin f_req0 = 0; f_req1 = 0; end
            @(negedge clk);
        end

        // reset mid-op
        req0 = 1; ctrl0 = 2'b00; opA0 = 20'h00005; opB0 = 20'h00006;
        @(negedge clk);
        check("rm_busy", busy, 1);
        rst = 1;
        #1;
        check("rm_busy0", busy, 0);
        check("rm_ack", {ack0, ack1}, 0);
        check("rm_res", result, 0);
        check("rm_valid", rvalid, 0);
        @(negedge clk);
        @(negedge clk);
        check("rm_noack", {ack0, ack1, busy}, 0);
        rst = 0;
        @(negedge clk);
        check("rm_rebusy", busy, 1);
        check("rm_early", ack0, 0);
        @(negedge clk);
        check("rm_ack0", ack0, 1);
        check("rm_res2", result, 20'h0000B);
        req0 = 0;
        @(negedge clk);
        check("rm_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
